// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : snake_pkg
//  Description : Grid bounds, coordinate widths and the food_placer FSM
//                state encoding shared by the playfield logic.
//  Contents    : GRID_X_MIN/GRID_X_MAX/GRID_Y_MIN/GRID_Y_MAX - legal play area
//                X_W/Y_W                                     - coordinate widths
//                fp_state_e                                  - food_placer states
//  Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    localparam int X_W = 6;
    localparam int Y_W = 5;

    localparam int GRID_X_MIN = 1;
    localparam int GRID_X_MAX = 38;
    localparam int GRID_Y_MIN = 1;
    localparam int GRID_Y_MAX = 28;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SAMPLE      = 3'd1,
        ST_QUERY       = 3'd2,
        ST_SCAN_Q      = 3'd3,
        ST_COMMIT_FAIL = 3'd4
    } fp_state_e;

endpackage : snake_pkg
`default_nettype wire

// File: rtl/grid_raster_step.sv
`default_nettype none
// ============================================================================
//  Module      : grid_raster_step
//  Description : Combinational grid helpers. Produces the next raster-order
//                cell after (cur_x_i, cur_y_i), wrapping column then row back
//                to the minimum corner, and clamps a raw random coordinate
//                into the legal play area (out-of-range -> minimum).
//  Ports       : cur_x_i/cur_y_i     - current cell
//                rand_x_i/rand_y_i   - raw random coordinate
//                step_x_o/step_y_o   - next cell in raster order
//                clamp_x_o/clamp_y_o - clamped random coordinate
//  Revision    : 1.0 - initial release
// ============================================================================
module grid_raster_step
    import snake_pkg::*;
#(
    parameter int X_MIN = GRID_X_MIN,
    parameter int X_MAX = GRID_X_MAX,
    parameter int Y_MIN = GRID_Y_MIN,
    parameter int Y_MAX = GRID_Y_MAX
) (
    input  logic [X_W-1:0] cur_x_i,
    input  logic [Y_W-1:0] cur_y_i,
    input  logic [X_W-1:0] rand_x_i,
    input  logic [Y_W-1:0] rand_y_i,
    output logic [X_W-1:0] step_x_o,
    output logic [Y_W-1:0] step_y_o,
    output logic [X_W-1:0] clamp_x_o,
    output logic [Y_W-1:0] clamp_y_o
);

    localparam logic [X_W-1:0] c_x_min = X_MIN[X_W-1:0];
    localparam logic [X_W-1:0] c_x_max = X_MAX[X_W-1:0];
    localparam logic [Y_W-1:0] c_y_min = Y_MIN[Y_W-1:0];
    localparam logic [Y_W-1:0] c_y_max = Y_MAX[Y_W-1:0];

    // The compare against the maximum happens before the increment is used,
    // so the adders never wrap at the port width.
    always_comb begin
        step_x_o = cur_x_i + 1'b1;
        step_y_o = cur_y_i;
        if (cur_x_i == c_x_max) begin
            step_x_o = c_x_min;
            if (cur_y_i == c_y_max) begin
                step_y_o = c_y_min;
            end else begin
                step_y_o = cur_y_i + 1'b1;
            end
        end
    end

    always_comb begin
        clamp_x_o = ((rand_x_i < c_x_min) || (rand_x_i > c_x_max)) ? c_x_min : rand_x_i;
        clamp_y_o = ((rand_y_i < c_y_min) || (rand_y_i > c_y_max)) ? c_y_min : rand_y_i;
    end

endmodule : grid_raster_step
`default_nettype wire

// File: rtl/food_placer.sv
`default_nettype none
// ============================================================================
//  Module      : food_placer
//  Description : Places a food item on a free grid cell. A request samples a
//                clamped random candidate and asks the occupancy lookup about
//                it; occupied candidates are retried with fresh samples up to
//                MAX_TRIES, after which a raster scan walks every cell once.
//                If the whole grid is occupied, place_fail is raised and held
//                until the next accepted request.
//  Ports       : clk, reset (async, active-low)
//                place_req                   - one-cycle placement request
//                rand_x/rand_y               - random position source
//                occ_query_valid/_x/_y       - candidate to occupancy lookup
//                occ_resp_valid/occ_hit      - occupancy answer
//                food_x/food_y/food_valid    - committed food position
//                busy/place_done/place_fail  - placement status
//  Revision    : 1.0 - initial release
// ============================================================================
module food_placer
    import snake_pkg::*;
#(
    parameter int X_MIN     = GRID_X_MIN,
    parameter int X_MAX     = GRID_X_MAX,
    parameter int Y_MIN     = GRID_Y_MIN,
    parameter int Y_MAX     = GRID_Y_MAX,
    parameter int MAX_TRIES = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           place_req,
    input  logic [X_W-1:0] rand_x,
    input  logic [Y_W-1:0] rand_y,
    output logic           occ_query_valid,
    output logic [X_W-1:0] occ_query_x,
    output logic [Y_W-1:0] occ_query_y,
    input  logic           occ_resp_valid,
    input  logic           occ_hit,
    output logic [X_W-1:0] food_x,
    output logic [Y_W-1:0] food_y,
    output logic           food_valid,
    output logic           busy,
    output logic           place_done,
    output logic           place_fail
);

    localparam int CELLS  = (X_MAX - X_MIN + 1) * (Y_MAX - Y_MIN + 1);
    localparam int SCAN_W = ($clog2(CELLS + 1) > 11) ? $clog2(CELLS + 1) : 11;
    localparam int TRY_W  = 4;

    localparam logic [SCAN_W-1:0] c_cells     = CELLS[SCAN_W-1:0];
    localparam logic [SCAN_W-1:0] c_scan_one  = {{(SCAN_W-1){1'b0}}, 1'b1};
    localparam logic [TRY_W-1:0]  c_max_tries = MAX_TRIES[TRY_W-1:0];
    localparam logic [TRY_W-1:0]  c_try_one   = {{(TRY_W-1){1'b0}}, 1'b1};

    fp_state_e state_q;
    fp_state_e state_d;

    logic [X_W-1:0]    cand_x_q;
    logic [Y_W-1:0]    cand_y_q;
    logic [TRY_W-1:0]  try_q;
    logic [SCAN_W-1:0] scan_q;
    logic [X_W-1:0]    food_x_q;
    logic [Y_W-1:0]    food_y_q;
    logic              food_valid_q;
    logic              place_done_q;
    logic              place_fail_q;

    logic [X_W-1:0]    w_step_x;
    logic [Y_W-1:0]    w_step_y;
    logic [X_W-1:0]    w_clamp_x;
    logic [Y_W-1:0]    w_clamp_y;

    grid_raster_step #(
        .X_MIN (X_MIN),
        .X_MAX (X_MAX),
        .Y_MIN (Y_MIN),
        .Y_MAX (Y_MAX)
    ) u_step (
        .cur_x_i   (cand_x_q),
        .cur_y_i   (cand_y_q),
        .rand_x_i  (rand_x),
        .rand_y_i  (rand_y),
        .step_x_o  (w_step_x),
        .step_y_o  (w_step_y),
        .clamp_x_o (w_clamp_x),
        .clamp_y_o (w_clamp_y)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (place_req) begin
                    state_d = ST_QUERY;
                end
            end
            ST_SAMPLE: begin
                state_d = ST_QUERY;
            end
            ST_QUERY: begin
                if (occ_resp_valid) begin
                    if (!occ_hit) begin
                        state_d = ST_IDLE;
                    end else if (try_q == c_max_tries) begin
                        state_d = ST_SCAN_Q;
                    end else begin
                        state_d = ST_SAMPLE;
                    end
                end
            end
            ST_SCAN_Q: begin
                if (occ_resp_valid) begin
                    if (!occ_hit) begin
                        state_d = ST_IDLE;
                    end else if (scan_q == c_cells) begin
                        state_d = ST_COMMIT_FAIL;
                    end
                end
            end
            ST_COMMIT_FAIL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs decoded from the current state
    // ------------------------------------------------------------------
    always_comb begin
        occ_query_valid = (state_q == ST_QUERY) || (state_q == ST_SCAN_Q);
        busy            = (state_q != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Candidate, counters and committed food position
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            try_q        <= '0;
            scan_q       <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            place_done_q <= 1'b0;
            place_fail_q <= 1'b0;
        end else begin
            place_done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (place_req) begin
                        cand_x_q     <= w_clamp_x;
                        cand_y_q     <= w_clamp_y;
                        try_q        <= c_try_one;
                        scan_q       <= '0;
                        food_valid_q <= 1'b0;
                        place_fail_q <= 1'b0;
                    end
                end
                ST_SAMPLE: begin
                    cand_x_q <= w_clamp_x;
                    cand_y_q <= w_clamp_y;
                    try_q    <= try_q + 1'b1;
                end
                ST_QUERY, ST_SCAN_Q: begin
                    if (occ_resp_valid) begin
                        if (!occ_hit) begin
                            food_x_q     <= cand_x_q;
                            food_y_q     <= cand_y_q;
                            food_valid_q <= 1'b1;
                            place_done_q <= 1'b1;
                        end else if (state_q == ST_QUERY) begin
                            // Random budget exhausted: the scan starts one
                            // step past the last random candidate.
                            if (try_q == c_max_tries) begin
                                cand_x_q <= w_step_x;
                                cand_y_q <= w_step_y;
                                scan_q   <= c_scan_one;
                            end
                        end else if (scan_q == c_cells) begin
                            // Every cell has been visited once: grid full.
                            place_fail_q <= 1'b1;
                        end else begin
                            cand_x_q <= w_step_x;
                            cand_y_q <= w_step_y;
                            scan_q   <= scan_q + 1'b1;
                        end
                    end
                end
                ST_COMMIT_FAIL: begin
                    place_fail_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign occ_query_x = cand_x_q;
    assign occ_query_y = cand_y_q;
    assign food_x      = food_x_q;
    assign food_y      = food_y_q;
    assign food_valid  = food_valid_q;
    assign place_done  = place_done_q;
    assign place_fail  = place_fail_q;

endmodule : food_placer
`default_nettype wire

// File: tb/tb_food_placer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_food_placer
//  Description : Scoreboard bench for food_placer. Each placement pushes the
//                expected query sequence and outcome, derived from the grid
//                rules with linear cell indices, into queues; a monitor pops
//                and compares whenever the DUT presents a query or finishes.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_food_placer;

    localparam int X_MIN     = 1;
    localparam int X_MAX     = 38;
    localparam int Y_MIN     = 1;
    localparam int Y_MAX     = 28;
    localparam int MAX_TRIES = 8;
    localparam int GW        = X_MAX - X_MIN + 1;
    localparam int GH        = Y_MAX - Y_MIN + 1;
    localparam int CELLS     = GW * GH;

    typedef struct {
        int x;
        int y;
    } coord_t;

    typedef struct {
        bit ok;
        int x;
        int y;
    } res_t;

    logic       clk             = 1'b0;
    logic       reset           = 1'b0;
    logic       place_req       = 1'b0;
    logic [5:0] rand_x          = '0;
    logic [4:0] rand_y          = '0;
    logic       occ_query_valid;
    logic [5:0] occ_query_x;
    logic [4:0] occ_query_y;
    logic       occ_resp_valid  = 1'b0;
    logic       occ_hit         = 1'b0;
    logic [5:0] food_x;
    logic [4:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       place_done;
    logic       place_fail;

    int n_checks = 0;
    int n_fail   = 0;

    coord_t exp_q[$];
    res_t   exp_r[$];

    // Transaction plan shared with the responder
    int plan_sx[MAX_TRIES];
    int plan_sy[MAX_TRIES];
    int plan_k    = 0;
    int plan_dmin = 0;
    int plan_dmax = 0;
    int txn_id    = 0;

    food_placer #(
        .X_MIN     (X_MIN),
        .X_MAX     (X_MAX),
        .Y_MIN     (Y_MIN),
        .Y_MAX     (Y_MAX),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .place_req       (place_req),
        .rand_x          (rand_x),
        .rand_y          (rand_y),
        .occ_query_valid (occ_query_valid),
        .occ_query_x     (occ_query_x),
        .occ_query_y     (occ_query_y),
        .occ_resp_valid  (occ_resp_valid),
        .occ_hit         (occ_hit),
        .food_x          (food_x),
        .food_y          (food_y),
        .food_valid      (food_valid),
        .busy            (busy),
        .place_done      (place_done),
        .place_fail      (place_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_x(input int v);
        return (v < X_MIN || v > X_MAX) ? X_MIN : v;
    endfunction

    function automatic int clamp_y(input int v);
        return (v < Y_MIN || v > Y_MAX) ? Y_MIN : v;
    endfunction

    // Reference model: the first MAX_TRIES queries are the clamped samples,
    // then cells are visited in raster order by linear index starting one
    // past the last random candidate. k = number of hits before the miss
    // (negative = every query hits).
    task automatic push_model(input int k);
        int     nq;
        int     base;
        int     lin;
        coord_t c;
        res_t   r;
        bit     ok;
        ok   = (k >= 0) && (k < MAX_TRIES + CELLS);
        nq   = ok ? k + 1 : MAX_TRIES + CELLS;
        base = (clamp_y(plan_sy[MAX_TRIES-1]) - Y_MIN) * GW + (clamp_x(plan_sx[MAX_TRIES-1]) - X_MIN);
        c.x  = 0;
        c.y  = 0;
        for (int i = 0; i < nq; i++) begin
            if (i < MAX_TRIES) begin
                c.x = clamp_x(plan_sx[i]);
                c.y = clamp_y(plan_sy[i]);
            end else begin
                lin = (base + (i - MAX_TRIES + 1)) % CELLS;
                c.x = X_MIN + (lin % GW);
                c.y = Y_MIN + (lin / GW);
            end
            exp_q.push_back(c);
        end
        r.ok = ok;
        r.x  = c.x;
        r.y  = c.y;
        exp_r.push_back(r);
    endtask

    task automatic random_samples(input int sx0, input int sy0);
        plan_sx[0] = sx0;
        plan_sy[0] = sy0;
        for (int i = 1; i < MAX_TRIES; i++) begin
            plan_sx[i] = $urandom_range(63, 0);
            plan_sy[i] = $urandom_range(31, 0);
        end
    endtask

    // ------------------------------------------------------------------
    // Occupancy responder: answers after a random delay, hits the first
    // plan_k queries, and loads the next planned sample on each hit so the
    // DUT's resample picks it up. rand churns while a query waits.
    // ------------------------------------------------------------------
    int responder_txn = 0;
    int n_ans         = 0;
    int wait_cnt      = 0;

    always @(negedge clk) begin
        occ_resp_valid = 1'b0;
        occ_hit        = 1'($urandom_range(1, 0));
        if (txn_id != responder_txn) begin
            responder_txn = txn_id;
            n_ans         = 0;
            wait_cnt      = $urandom_range(plan_dmax, plan_dmin);
            rand_x        = 6'(plan_sx[0]);
            rand_y        = 5'(plan_sy[0]);
        end else if (reset && occ_query_valid) begin
            if (wait_cnt > 0) begin
                wait_cnt--;
                rand_x = 6'($urandom_range(63, 0));
                rand_y = 5'($urandom_range(31, 0));
            end else begin
                occ_resp_valid = 1'b1;
                occ_hit        = (plan_k < 0) || (n_ans < plan_k);
                if (occ_hit && (n_ans + 1 < MAX_TRIES)) begin
                    rand_x = 6'(plan_sx[n_ans+1]);
                    rand_y = 5'(plan_sy[n_ans+1]);
                end
                n_ans++;
                wait_cnt = $urandom_range(plan_dmax, plan_dmin);
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    bit     prev_qv   = 1'b0;
    bit     prev_busy = 1'b0;
    bit     chk_low   = 1'b0;
    bit     have_cur  = 1'b0;
    coord_t cur;
    res_t   res;

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            prev_qv   = 1'b0;
            prev_busy = 1'b0;
            chk_low   = 1'b0;
            have_cur  = 1'b0;
        end else begin
            if (chk_low) begin
                check("place_done_pulse_width", place_done, 0);
                chk_low = 1'b0;
            end
            if (occ_query_valid) begin
                if (!prev_qv || occ_resp_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_query: got (%0d,%0d), expected no query", occ_query_x, occ_query_y);
                        have_cur = 1'b0;
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        check("query_x", occ_query_x, cur.x);
                        check("query_y", occ_query_y, cur.y);
                    end
                end else if (have_cur) begin
                    check("query_x_stable", occ_query_x, cur.x);
                    check("query_y_stable", occ_query_y, cur.y);
                end
            end
            if (prev_busy && !busy) begin
                if (exp_r.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: got done=%0d fail=%0d, expected no completion", place_done, place_fail);
                end else begin
                    res = exp_r.pop_front();
                    check("place_done", place_done, res.ok);
                    check("place_fail", place_fail, !res.ok);
                    check("food_valid", food_valid, res.ok);
                    if (res.ok) begin
                        check("food_x", food_x, res.x);
                        check("food_y", food_y, res.y);
                    end
                end
                chk_low = 1'b1;
            end else if (place_done) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_place_done: got 1, expected 0 (busy=%0d)", busy);
            end
            prev_qv   = occ_query_valid;
            prev_busy = busy;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic run_txn(input int k, input int dmin, input int dmax, input bit poke, output int lat);
        int budget;
        bit done;
        push_model(k);
        @(negedge clk);
        plan_k    = k;
        plan_dmin = dmin;
        plan_dmax = dmax;
        txn_id++;
        @(negedge clk);
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        budget = (MAX_TRIES + CELLS + 2) * (dmax + 3) + 20;
        done   = 1'b0;
        lat    = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                lat  = c;
                break;
            end
            place_req = poke && ((c % 3) == 0);
        end
        place_req = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn_timeout: busy got 1 after %0d cycles, expected 0", budget);
        end
        repeat (2) @(negedge clk);
    endtask

    int lat;

    initial begin
        for (int i = 0; i < MAX_TRIES; i++) begin
            plan_sx[i] = 0;
            plan_sy[i] = 0;
        end
        reset     = 1'b0;
        place_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_food_x", food_x, 0);
        check("rst_food_y", food_y, 0);
        check("rst_food_valid", food_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_place_done", place_done, 0);
        check("rst_place_fail", place_fail, 0);
        check("rst_query_valid", occ_query_valid, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic: same-cycle miss commits one edge after the request edge
        random_samples(12, 7);
        run_txn(0, 0, 0, 1'b0, lat);
        check("basic_latency", lat, 0);

        // Clamp of out-of-range samples
        random_samples(0, 31);
        run_txn(0, 0, 0, 1'b0, lat);
        random_samples(45, 0);
        run_txn(0, 1, 2, 1'b0, lat);

        // Retry: three hits then a miss
        random_samples($urandom_range(63, 0), $urandom_range(31, 0));
        run_txn(3, 0, 2, 1'b0, lat);

        // Fallback scan wrapping from the last cell
        random_samples(5, 5);
        plan_sx[MAX_TRIES-1] = 38;
        plan_sy[MAX_TRIES-1] = 28;
        run_txn(MAX_TRIES + 2, 0, 1, 1'b0, lat);

        // Slow responder: query must hold still
        random_samples(20, 20);
        run_txn(2, 5, 5, 1'b0, lat);

        // Requests while busy are ignored
        random_samples(30, 3);
        run_txn(5, 1, 3, 1'b1, lat);

        // Grid full, then a fresh request clears place_fail
        random_samples(7, 9);
        run_txn(-1, 0, 0, 1'b0, lat);
        random_samples(9, 9);
        run_txn(0, 0, 0, 1'b0, lat);

        // Randomised placements
        for (int t = 0; t < 8; t++) begin
            random_samples($urandom_range(63, 0), $urandom_range(31, 0));
            run_txn($urandom_range(MAX_TRIES + 6, 0), 0, 2, 1'($urandom_range(1, 0)), lat);
        end

        // Asynchronous reset in the middle of a query
        random_samples(20, 10);
        push_model(0);
        @(negedge clk);
        plan_k    = 0;
        plan_dmin = 50;
        plan_dmax = 50;
        txn_id++;
        @(negedge clk);
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_query_valid", occ_query_valid, 0);
        check("async_rst_food_x", food_x, 0);
        check("async_rst_food_y", food_y, 0);
        check("async_rst_food_valid", food_valid, 0);
        check("async_rst_place_done", place_done, 0);
        check("async_rst_place_fail", place_fail, 0);
        exp_q.delete();
        exp_r.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        random_samples(33, 17);
        run_txn(1, 0, 1, 1'b0, lat);

        repeat (4) @(negedge clk);
        check("leftover_queries", exp_q.size(), 0);
        check("leftover_results", exp_r.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_food_placer
`default_nettype wire

// File: doc/food_placer.md
Name: food_placer

Overview:
Downstream consumer of the pseudo-random position generator (rand x 6-bit, rand y 5-bit, new value every clk). On a placement request, samples a candidate cell and checks it against the snake-body occupancy lookup. Retries with fresh random samples on collision, then falls back to a deterministic raster scan. Holds the committed food position for the renderer and the collision logic.

Parameters:
X_MIN, 1, lowest legal column
X_MAX, 38, highest legal column
Y_MIN, 1, lowest legal row
Y_MAX, 28, highest legal row
MAX_TRIES, 8, random candidates tried before raster-scan fallback (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
place_req  in  1  one-cycle pulse: place new food (game start / food eaten)
rand_x  in  6  random column from generator
rand_y  in  5  random row from generator
occ_query_valid  out  1  candidate presented for occupancy check
occ_query_x  out  6  candidate column
occ_query_y  out  5  candidate row
occ_resp_valid  in  1  occupancy answer valid (same cycle or later)
occ_hit  in  1  candidate occupied by snake (valid with occ_resp_valid)
food_x  out  6  committed food column
food_y  out  5  committed food row
food_valid  out  1  food position valid / displayable
busy  out  1  placement in progress
place_done  out  1  one-cycle pulse on commit
place_fail  out  1  grid full, no free cell; sticky until next accepted place_req

Behaviour:
- Reset (reset=0, async): state IDLE; food_x=0, food_y=0, food_valid=0, busy=0, place_done=0, place_fail=0, occ_query_valid=0, try counter=0, scan counter=0.
- States: IDLE, SAMPLE, QUERY, SCAN_Q, COMMIT_FAIL (one-cycle fail state returning to IDLE).
- IDLE: busy=0. place_req=1 at an edge: latch candidate from rand_x/rand_y (clamped), clear food_valid and place_fail, try count=1, go to QUERY.
- Clamp: x<X_MIN or x>X_MAX becomes X_MIN; y<Y_MIN or y>Y_MAX becomes Y_MIN. Applied on every random sample.
- QUERY / SCAN_Q: occ_query_valid=1 (Moore, from state); occ_query_x/y = candidate, stable until the response. Remain in state while occ_resp_valid=0. There is no timeout.
- Response miss (occ_hit=0): at that edge, food_x/y=candidate, food_valid=1, place_done=1 for one cycle, go to IDLE.
- Response hit in QUERY, try<MAX_TRIES: go to SAMPLE. SAMPLE latches a new clamped random candidate, increments try, returns to QUERY.
- Response hit in QUERY, try==MAX_TRIES: candidate advances one raster step, scan count=1, go to SCAN_Q.
- Raster step: x+1; if x==X_MAX then x=X_MIN and y+1; if y==Y_MAX too then y=Y_MIN (full wrap).
- Response hit in SCAN_Q: if scan count==(X_MAX-X_MIN+1)*(Y_MAX-Y_MIN+1) (1064 default), go to COMMIT_FAIL. Otherwise raster step, scan count+1, stay in SCAN_Q. Scan counter is 11 bits minimum.
- COMMIT_FAIL: place_fail=1 (sticky), food_valid stays 0, go to IDLE.
- busy=1 in every state except IDLE.
- place_req while busy: ignored, no queuing.
- place_req coinciding with the place_done edge: not accepted, because the FSM is not in IDLE at that edge.
- Minimum latency: req at edge N, combinational responder hits 0, food_valid=1 after edge N+1. Each retry adds 2 cycles plus responder delay.
- Reset mid-operation: immediate return to the reset values. Any in-flight query is abandoned; the responder must tolerate occ_query_valid dropping.
- All coordinate arithmetic is unsigned at port widths; raster step compares before incrementing, so no overflow.

Decomposition:
- Shared package snake_pkg: grid bounds (X_MIN/X_MAX/Y_MIN/Y_MAX), coordinate widths (6/5), FSM state encoding for food_placer.
- One natural sub-module, grid_raster_step: combinational next-cell-with-wrap plus clamp function, reused by the body/renderer logic.

Test Plan:
- Basic: reset released, rand=(12,7), place_req pulse, responder hit=0 same cycle -> food=(12,7), food_valid=1 and place_done pulse one cycle after req edge, busy back to 0.
- Clamp: rand=(0,31) or (45,0) -> occ_query shows (1,1); commits (1,1) on miss.
- Retry: responder hits the first 3 candidates, then misses; rand changes each cycle -> exactly 4 queries, commit equals the 4th clamped sample, no SCAN_Q entered.
- Fallback with wrap: MAX_TRIES hits, last candidate (38,28), next responses hit, hit, miss -> scan queries (1,1), (2,1), (3,1); commit (3,1).
- Full grid: responder always hits -> MAX_TRIES+1064 queries, then place_fail=1, food_valid=0, busy=0. A new place_req clears place_fail.
- Robustness: place_req pulses while busy are ignored (single place_done). Responder delays occ_resp_valid 5 cycles -> query held stable. reset=0 mid-query -> all outputs return to reset values asynchronously.
